// File: rtl/custom_axi_ip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : custom_axi_ip_pkg
// Description : Shared constants, types and helpers for the register-to-
//               hardware mailbox (custom_axi_ip_mbox) and its channel FIFO.
//               - default channel count / data width / FIFO depth
//               - cnt_width(): width of an occupancy counter for a given depth
//               - chan_status_t: {head_data, head_valid} record as seen on
//                 the ip2reg side for a default-width channel
//               - ch_lsb(): LSB of channel ch in a bus where ch0 is the MSBs
// Revision    : 1.0 - initial release
// ============================================================================
package custom_axi_ip_pkg;

    localparam int unsigned c_num_ch_default = 3;
    localparam int unsigned c_dw_default     = 32;
    localparam int unsigned c_depth_default  = 4;

    // Counter must hold 0..DEPTH inclusive, hence one bit more than the pointers.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [c_dw_default-1:0] head_data;
        logic                    head_valid;
    } chan_status_t;

    // Channel 0 occupies the most significant slice of every packed bus.
    function automatic int unsigned ch_lsb(input int unsigned ch,
                                           input int unsigned num_ch,
                                           input int unsigned width);
        return (num_ch - 1 - ch) * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/custom_axi_ip_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : custom_axi_ip_chan_fifo
// Description : One mailbox channel: DEPTH-entry FIFO fed by register writes
//               and drained by a valid/ready hardware port, plus the accept
//               ack pulse, ip2reg update pulse and sticky overflow flag.
// Ports       : clk_i, rst_i      clock, synchronous active-high reset
//               i_push, i_data    push strobe and write data
//               i_ready           hardware pop request
//               i_ovf_clr         overflow clear
//               i_flush           channel flush (CUSTOM_AXI_IP_MBOX_FLUSH_EN)
//               o_ack             push accepted, one cycle after the push
//               o_upd             push/pop/flush happened last cycle
//               o_data, o_valid   FIFO head and non-empty flag
//               o_ovf             sticky overflow flag
// Config      : CUSTOM_AXI_IP_MBOX_FLUSH_EN adds i_flush.
// Revision    : 1.0 - initial release
// ============================================================================
module custom_axi_ip_chan_fifo
    import custom_axi_ip_pkg::*;
#(
    parameter int unsigned DW    = c_dw_default,
    parameter int unsigned DEPTH = c_depth_default
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    input  logic          i_ovf_clr,
`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
    input  logic          i_flush,
`endif
    output logic          o_ack,
    output logic          o_upd,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_ovf
);

    localparam int unsigned      c_aw      = $clog2(DEPTH);
    localparam int unsigned      c_cw      = cnt_width(DEPTH);
    localparam logic [c_cw-1:0]  c_full    = c_cw'(DEPTH);
    localparam logic [c_cw-1:0]  c_cnt_one = c_cw'(1);
    localparam logic [c_aw-1:0]  c_ptr_one = c_aw'(1);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            r_ack;
    logic            r_upd;
    logic            r_ovf;

    logic w_flush;
    logic w_full;
    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_drop;

`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // A flush suppresses both sides: the pop is ignored and the push is
    // dropped silently (no ack, no overflow).
    assign w_full  = (r_count == c_full);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & i_ready & ~w_flush;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push  = i_push & ~w_flush & (~w_full | w_pop);
    assign w_drop  = i_push & ~w_flush & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
            r_upd    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_ack <= w_push;
            r_upd <= w_push | w_pop | w_flush;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_cnt_one;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_cnt_one;
                end
                // A drop in the same cycle as a clear keeps the flag set.
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end else if (i_ovf_clr) begin
                    r_ovf <= 1'b0;
                end
            end
        end
    end

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Head is forced to zero while empty so stale storage never leaks out.
    assign o_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_valid = w_valid;
    assign o_ack   = r_ack;
    assign o_upd   = r_upd;
    assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/custom_axi_ip_mbox.sv
`default_nettype none
// ============================================================================
// Module      : custom_axi_ip_mbox
// Description : Parametrised multi-channel register-to-hardware mailbox.
//               Packs/unpacks NUM_CH independent channel FIFOs; channel 0
//               occupies the MSBs of every multi-channel bus.
// Ports       : clk_i, rst_i     clock, synchronous active-high reset
//               reg2ip_data      NUM_CH*DW write data
//               reg2ip_en_in     per-channel push strobe
//               reg2ip_en_out    per-channel push-accepted pulse
//               ip2reg_data      per-channel {head_data, head_valid}
//               ip2reg_en        per-channel update pulse
//               hw_data_o        per-channel head data
//               hw_valid_o       per-channel non-empty
//               hw_ready_i       per-channel pop
//               ovf_o            per-channel sticky overflow
//               ovf_clr_i        per-channel overflow clear
//               flush_i          per-channel flush (CUSTOM_AXI_IP_MBOX_FLUSH_EN)
// Config      : CUSTOM_AXI_IP_MBOX_FLUSH_EN adds flush_i.
// Revision    : 1.0 - initial release
// ============================================================================
module custom_axi_ip_mbox
    import custom_axi_ip_pkg::*;
#(
    parameter int unsigned NUM_CH = c_num_ch_default,
    parameter int unsigned DW     = c_dw_default,
    parameter int unsigned DEPTH  = c_depth_default
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH*DW-1:0]     reg2ip_data,
    input  logic [NUM_CH-1:0]        reg2ip_en_in,
    output logic [NUM_CH-1:0]        reg2ip_en_out,
    output logic [NUM_CH*(DW+1)-1:0] ip2reg_data,
    output logic [NUM_CH-1:0]        ip2reg_en,
    output logic [NUM_CH*DW-1:0]     hw_data_o,
    output logic [NUM_CH-1:0]        hw_valid_o,
    input  logic [NUM_CH-1:0]        hw_ready_i,
    output logic [NUM_CH-1:0]        ovf_o,
    input  logic [NUM_CH-1:0]        ovf_clr_i
`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
    ,
    input  logic [NUM_CH-1:0]        flush_i
`endif
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int unsigned c_lo  = ch_lsb(c, NUM_CH, DW);
        localparam int unsigned c_slo = ch_lsb(c, NUM_CH, DW + 1);

        logic [DW-1:0] w_head;
        logic          w_valid;

        custom_axi_ip_chan_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .i_push    (reg2ip_en_in[c]),
            .i_data    (reg2ip_data[c_lo +: DW]),
            .i_ready   (hw_ready_i[c]),
            .i_ovf_clr (ovf_clr_i[c]),
`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
            .i_flush   (flush_i[c]),
`endif
            .o_ack     (reg2ip_en_out[c]),
            .o_upd     (ip2reg_en[c]),
            .o_data    (w_head),
            .o_valid   (w_valid),
            .o_ovf     (ovf_o[c])
        );

        assign hw_data_o[c_lo +: DW]          = w_head;
        assign hw_valid_o[c]                  = w_valid;
        assign ip2reg_data[c_slo +: (DW + 1)] = {w_head, w_valid};
    end

endmodule
`default_nettype wire

// File: tb/tb_custom_axi_ip_mbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_custom_axi_ip_mbox
// Description : Self-checking bench for custom_axi_ip_mbox (3 ch, 32 b, 4 deep).
//               A per-channel queue model predicts acks, updates, overflow,
//               valid and head data; a vector table and short hand-written
//               sequences cover the listed corner cases.
//               Honours CUSTOM_AXI_IP_MBOX_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_custom_axi_ip_mbox;
    import custom_axi_ip_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic [NUM_CH*DW-1:0]     reg2ip_data;
    logic [NUM_CH-1:0]        reg2ip_en_in;
    logic [NUM_CH-1:0]        reg2ip_en_out;
    logic [NUM_CH*(DW+1)-1:0] ip2reg_data;
    logic [NUM_CH-1:0]        ip2reg_en;
    logic [NUM_CH*DW-1:0]     hw_data_o;
    logic [NUM_CH-1:0]        hw_valid_o;
    logic [NUM_CH-1:0]        hw_ready_i;
    logic [NUM_CH-1:0]        ovf_o;
    logic [NUM_CH-1:0]        ovf_clr_i;
`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
    logic [NUM_CH-1:0]        flush_i;
`endif

    always #5 clk = ~clk;

    custom_axi_ip_mbox #(
        .NUM_CH (NUM_CH),
        .DW     (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .reg2ip_data   (reg2ip_data),
        .reg2ip_en_in  (reg2ip_en_in),
        .reg2ip_en_out (reg2ip_en_out),
        .ip2reg_data   (ip2reg_data),
        .ip2reg_en     (ip2reg_en),
        .hw_data_o     (hw_data_o),
        .hw_valid_o    (hw_valid_o),
        .hw_ready_i    (hw_ready_i),
        .ovf_o         (ovf_o),
        .ovf_clr_i     (ovf_clr_i)
`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
        ,
        .flush_i       (flush_i)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel plus the overflow flags.
    logic [DW-1:0]     mq [NUM_CH][$];
    logic [NUM_CH-1:0] m_ovf = '0;

    typedef struct {
        logic [NUM_CH-1:0]    en;
        logic [NUM_CH*DW-1:0] din;
        logic [NUM_CH-1:0]    rdy;
        logic [NUM_CH-1:0]    clr;
        logic [NUM_CH-1:0]    exp_ack;
        logic [NUM_CH-1:0]    exp_valid;
        logic [NUM_CH-1:0]    exp_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH*DW-1:0] pk(input int ch, input logic [DW-1:0] v);
        logic [NUM_CH*DW-1:0] r;
        r = '0;
        r[(NUM_CH-1-ch)*DW +: DW] = v;
        return r;
    endfunction

    function automatic vec_t mk(input logic [NUM_CH-1:0] en, input logic [NUM_CH*DW-1:0] din,
                                input logic [NUM_CH-1:0] rdy, input logic [NUM_CH-1:0] clr,
                                input logic [NUM_CH-1:0] ack, input logic [NUM_CH-1:0] vld,
                                input logic [NUM_CH-1:0] ovf);
        vec_t v;
        v.en = en; v.din = din; v.rdy = rdy; v.clr = clr;
        v.exp_ack = ack; v.exp_valid = vld; v.exp_ovf = ovf;
        return v;
    endfunction

    // One clock: drive, score pops against the model, clock, compare outputs.
    task automatic cycle(input logic [NUM_CH-1:0] en, input logic [NUM_CH*DW-1:0] din,
                         input logic [NUM_CH-1:0] rdy, input logic [NUM_CH-1:0] clr,
                         input logic [NUM_CH-1:0] fl, input logic rst);
        logic [NUM_CH-1:0]        e_ack, e_upd, e_valid;
        logic [NUM_CH*DW-1:0]     e_hw, m_hw;
        logic [NUM_CH*(DW+1)-1:0] e_ip, m_ip;
        chan_status_t             s;
        bit                       full, pop, push, drop, nonempty;

        reg2ip_en_in = en;
        reg2ip_data  = din;
        hw_ready_i   = rdy;
        ovf_clr_i    = clr;
        rst_i        = rst;
`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
        flush_i      = fl;
`endif
        #1;
        e_ack = '0;
        e_upd = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                mq[c].delete();
                m_ovf[c] = 1'b0;
            end else begin
                full = (mq[c].size() == DEPTH);
                pop  = !fl[c] && (mq[c].size() != 0) && rdy[c];
                if (pop) begin
                    chk($sformatf("pop_data ch%0d", c), hw_data_o[(NUM_CH-1-c)*DW +: DW], mq[c][0]);
                    void'(mq[c].pop_front());
                end
                push = !fl[c] && en[c] && (!full || pop);
                drop = !fl[c] && en[c] && full && !pop;
                if (push) mq[c].push_back(din[(NUM_CH-1-c)*DW +: DW]);
                if (fl[c]) begin
                    mq[c].delete();
                    m_ovf[c] = 1'b0;
                end else if (drop) begin
                    m_ovf[c] = 1'b1;
                end else if (clr[c]) begin
                    m_ovf[c] = 1'b0;
                end
                e_ack[c] = push;
                e_upd[c] = push || pop || fl[c];
            end
        end

        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            nonempty     = (mq[c].size() != 0);
            e_valid[c]   = nonempty;
            s.head_data  = nonempty ? mq[c][0] : '0;
            s.head_valid = nonempty;
            e_ip[(NUM_CH-1-c)*(DW+1) +: (DW+1)] = s;
            m_ip[(NUM_CH-1-c)*(DW+1) +: (DW+1)] = {{DW{nonempty}}, 1'b1};
            e_hw[(NUM_CH-1-c)*DW +: DW]         = s.head_data;
            m_hw[(NUM_CH-1-c)*DW +: DW]         = {DW{nonempty}};
        end
        chk("ack",     reg2ip_en_out,      e_ack);
        chk("upd",     ip2reg_en,          e_upd);
        chk("ovf",     ovf_o,              m_ovf);
        chk("valid",   hw_valid_o,         e_valid);
        chk("ip2reg",  ip2reg_data & m_ip, e_ip);
        chk("hw_data", hw_data_o & m_hw,   e_hw);
    endtask

    task automatic idle(input logic [NUM_CH-1:0] rdy);
        cycle('0, '0, rdy, '0, '0, 1'b0);
    endtask

    initial begin
        rst_i        = 1'b1;
        reg2ip_en_in = '0;
        reg2ip_data  = '0;
        hw_ready_i   = '0;
        ovf_clr_i    = '0;
`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
        flush_i      = '0;
`endif

        // ch0 fill / overflow / clear / drain
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(3'b001, pk(0, 32'(i * 'h11)), 3'b000, 3'b000,
                             (i <= 4) ? 3'b001 : 3'b000, 3'b001, (i <= 4) ? 3'b000 : 3'b001));
        tbl.push_back(mk(3'b001, pk(0, 32'h66), 3'b000, 3'b001, 3'b000, 3'b001, 3'b001));
        tbl.push_back(mk(3'b000, '0,            3'b000, 3'b001, 3'b000, 3'b001, 3'b000));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(3'b000, '0, 3'b001, 3'b000, 3'b000, (i < 4) ? 3'b001 : 3'b000, 3'b000));
        // ch2 full with simultaneous push and pop
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(3'b100, pk(2, 32'hA0 + 32'(i)), 3'b000, 3'b000, 3'b100, 3'b100, 3'b000));
        tbl.push_back(mk(3'b100, pk(2, 32'hAA), 3'b100, 3'b000, 3'b100, 3'b100, 3'b000));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(3'b000, '0, 3'b100, 3'b000, 3'b000, (i < 4) ? 3'b100 : 3'b000, 3'b000));

        // Reset
        cycle('0, '0, '0, '0, '0, 1'b1);
        cycle('0, '0, '0, '0, '0, 1'b1);
        chk("reset ip2reg", ip2reg_data, '0);
        chk("reset hw_data", hw_data_o, '0);

        // Single push on ch1
        cycle(3'b010, pk(1, 32'h0000_2468), '0, '0, '0, 1'b0);
        chk("single ack", reg2ip_en_out, 3'b010);
        chk("single ip2reg ch1", ip2reg_data[(DW+1) +: (DW+1)], {32'h0000_2468, 1'b1});
        chk("single upd", ip2reg_en, 3'b010);
        idle('0);
        chk("single upd ends", ip2reg_en, 3'b000);
        idle(3'b010);

        // Vector table
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].en, tbl[i].din, tbl[i].rdy, tbl[i].clr, '0, 1'b0);
            chk($sformatf("tbl%0d ack", i),   reg2ip_en_out, tbl[i].exp_ack);
            chk($sformatf("tbl%0d valid", i), hw_valid_o,    tbl[i].exp_valid);
            chk($sformatf("tbl%0d ovf", i),   ovf_o,         tbl[i].exp_ovf);
        end

        // Wrap-around on ch0 while ch1 holds one entry
        cycle(3'b010, pk(1, 32'h1357), '0, '0, '0, 1'b0);
        cycle(3'b001, pk(0, 32'd1), '0, '0, '0, 1'b0);
        for (int i = 2; i <= 10; i++)
            cycle(3'b001, pk(0, 32'(i)), 3'b001, '0, '0, 1'b0);
        idle(3'b001);
        chk("indep ch1", ip2reg_data[(DW+1) +: (DW+1)], {32'h1357, 1'b1});
        chk("wrap ch0 empty", hw_valid_o[0], 1'b0);

        // All channels at once
        cycle(3'b111, pk(0, 32'hC0) | pk(1, 32'hC1) | pk(2, 32'hC2), '0, '0, '0, 1'b0);
        chk("all ack", reg2ip_en_out, 3'b111);
        idle(3'b111);
        idle(3'b111);
        idle('0);

`ifdef CUSTOM_AXI_IP_MBOX_FLUSH_EN
        // Flush with same-cycle push and pop on a full, overflowed channel
        for (int i = 1; i <= 5; i++)
            cycle(3'b001, pk(0, 32'h70 + 32'(i)), '0, '0, '0, 1'b0);
        chk("pre-flush ovf", ovf_o, 3'b001);
        cycle(3'b001, pk(0, 32'h77), 3'b001, '0, 3'b001, 1'b0);
        chk("flush no ack", reg2ip_en_out, 3'b000);
        chk("flush empty", hw_valid_o, 3'b000);
        chk("flush upd", ip2reg_en, 3'b001);
        chk("flush ovf", ovf_o, 3'b000);
        idle('0);
`endif

        // Reset mid-traffic
        cycle(3'b111, pk(0, 32'hD0) | pk(1, 32'hD1) | pk(2, 32'hD2), '0, '0, '0, 1'b0);
        cycle(3'b111, pk(0, 32'hE0) | pk(1, 32'hE1) | pk(2, 32'hE2), 3'b111, '0, '0, 1'b1);
        cycle(3'b111, pk(0, 32'hF0) | pk(1, 32'hF1) | pk(2, 32'hF2), 3'b111, '0, '0, 1'b1);
        chk("midreset ip2reg", ip2reg_data, '0);
        chk("midreset ack", reg2ip_en_out, 3'b000);
        idle('0);
        chk("postreset ack", reg2ip_en_out, 3'b000);
        chk("postreset valid", hw_valid_o, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
